// File: rtl/fx2_pkg.sv
// fx2_pkg: shared FX2 constants, op encodings and shift-count helper
package fx2_pkg;

    localparam int DW = 128;
    localparam int RW = 7;

    typedef enum logic [1:0] {
        OP_ROTMI   = 2'b00,
        OP_ROTMAI  = 2'b01,
        OP_ROTHMI  = 2'b10,
        OP_ROTMAHI = 2'b11
    } op_e;

    // Shift immediates encode the right-shift amount as a negative I7 value.
    function automatic logic [5:0] neg_cnt(input logic [6:0] imme7, input logic [5:0] mask);
        logic [6:0] n;
        n = -imme7;
        return n[5:0] & mask;
    endfunction

endpackage

// File: rtl/shri_pipe_shr_slot.sv
// shr_slot: combinational right shift of one SW-bit slot, logical or sign-filling
//   t     in  SW  slot data, t[SW-1] is the slot MSB
//   s     in  6   shift count, counts >= SW clear or sign-fill the slot
//   arith in  1   fill vacated bits with the slot MSB
//   r     out SW  shifted slot
module shr_slot #(
    parameter int SW = 32
) (
    input  logic [SW-1:0] t,
    input  logic [5:0]    s,
    input  logic          arith,
    output logic [SW-1:0] r
);

    logic sign;

    // An arithmetic shift of the sign-extended slot saturates to all-fill for large counts.
    always_comb begin
        sign = arith & t[SW-1];
        r    = SW'($signed({sign, t}) >>> s);
    end

endmodule

// File: rtl/shri_pipe.sv
// shri_pipe: two-stage FX2 right-shift-immediate unit (rotmi/rotmai/rothmi/rotmahi)
//   clk, reset            clock, synchronous active-high reset
//   in_valid, op, ra      issued op, opcode and source quadword
//   imme7, rt_in          I7 immediate and destination register
//   stall, flush          hold both stages / kill in-flight ops
//   out_valid, result     registered result and its valid
//   rt_out                destination register of result
module shri_pipe
    import fx2_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [1:0]    op,
    input  logic [DW-1:0] ra,
    input  logic [6:0]    imme7,
    input  logic [RW-1:0] rt_in,
    input  logic          stall,
    input  logic          flush,
    output logic          out_valid,
    output logic [DW-1:0] result,
    output logic [RW-1:0] rt_out
);

    logic          v1_q, v1_d, vo_q, vo_d, issue, adv;
    logic [1:0]    op1_q, op1_d;
    logic [5:0]    cnt1_q, cnt1_d;
    logic [DW-1:0] a1_q, a1_d, res_q, res_d, wres, hres;
    logic [RW-1:0] rt1_q, rt1_d, rto_q, rto_d;

    // op[0] selects arithmetic, op[1] selects halfword slots.
    for (genvar w = 0; w < DW / 32; w++) begin : g_w
        shr_slot #(.SW(32)) u_w (.t(a1_q[32*w +: 32]), .s(cnt1_q), .arith(op1_q[0]), .r(wres[32*w +: 32]));
    end

    for (genvar h = 0; h < DW / 16; h++) begin : g_h
        shr_slot #(.SW(16)) u_h (.t(a1_q[16*h +: 16]), .s(cnt1_q), .arith(op1_q[0]), .r(hres[16*h +: 16]));
    end

    // Data registers only load on real transfers so result stays quiet on bubbles.
    always_comb begin
        issue  = in_valid & ~stall;
        adv    = v1_q & ~stall & ~flush;
        v1_d   = flush ? 1'b0 : stall ? v1_q : in_valid;
        op1_d  = issue ? op : op1_q;
        a1_d   = issue ? ra : a1_q;
        rt1_d  = issue ? rt_in : rt1_q;
        cnt1_d = issue ? neg_cnt(imme7, op[1] ? 6'h1F : 6'h3F) : cnt1_q;
        vo_d   = flush ? 1'b0 : stall ? vo_q : v1_q;
        res_d  = adv ? (op1_q[1] ? hres : wres) : res_q;
        rto_d  = adv ? rt1_q : rto_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v1_q   <= 1'b0;
            op1_q  <= '0;
            a1_q   <= '0;
            rt1_q  <= '0;
            cnt1_q <= '0;
            vo_q   <= 1'b0;
            res_q  <= '0;
            rto_q  <= '0;
        end else begin
            v1_q   <= v1_d;
            op1_q  <= op1_d;
            a1_q   <= a1_d;
            rt1_q  <= rt1_d;
            cnt1_q <= cnt1_d;
            vo_q   <= vo_d;
            res_q  <= res_d;
            rto_q  <= rto_d;
        end
    end

    assign out_valid = vo_q;
    assign result    = res_q;
    assign rt_out    = rto_q;

endmodule

// File: tb/tb_shri_pipe.sv
// tb_shri_pipe: directed vector table plus stall/flush/reset sequences for shri_pipe
module tb_shri_pipe;
    import fx2_pkg::*;

    typedef struct {
        logic [1:0]   op;
        logic [127:0] ra;
        logic [6:0]   imm;
        logic [127:0] exp;
    } vec_t;

    logic         clk = 1'b0, reset = 1'b1, in_valid = 1'b0, stall = 1'b0, flush = 1'b0;
    logic [1:0]   op = '0;
    logic [127:0] ra = '0;
    logic [6:0]   imme7 = '0;
    logic [6:0]   rt_in = '0;
    logic         out_valid;
    logic [127:0] result;
    logic [6:0]   rt_out;
    int           n_chk = 0, n_fail = 0;
    vec_t         vt[16];

    shri_pipe dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .op(op), .ra(ra), .imme7(imme7),
        .rt_in(rt_in), .stall(stall), .flush(flush), .out_valid(out_valid), .result(result),
        .rt_out(rt_out)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input int i, input logic [6:0] rt);
        in_valid = 1'b1;
        op       = vt[i].op;
        ra       = vt[i].ra;
        imme7    = vt[i].imm;
        rt_in    = rt;
    endtask

    task automatic chk_out(input string nm, input int i, input logic [6:0] rt);
        chk({nm, " valid"}, 128'(out_valid), 128'd1);
        chk({nm, " result"}, result, vt[i].exp);
        chk({nm, " rt"}, 128'(rt_out), 128'(rt));
    endtask

    initial begin
        vt[0]  = '{OP_ROTMI,   {4{32'h8000_0001}}, 7'h7C, {4{32'h0800_0000}}};
        vt[1]  = '{OP_ROTMAI,  {4{32'h8000_0000}}, 7'h60, {4{32'hFFFF_FFFF}}};
        vt[2]  = '{OP_ROTMI,   {4{32'h8000_0000}}, 7'h60, 128'h0};
        vt[3]  = '{OP_ROTHMI,  {8{16'hF00F}},      7'h7F, {8{16'h7807}}};
        vt[4]  = '{OP_ROTMAHI, {8{16'hF00F}},      7'h7F, {8{16'hF807}}};
        vt[5]  = '{OP_ROTHMI,  {8{16'hF00F}},      7'h00, {8{16'hF00F}}};
        vt[6]  = '{OP_ROTMAI,  {4{32'h8000_0001}}, 7'h00, {4{32'h8000_0001}}};
        vt[7]  = '{OP_ROTMI,   {32'h1234_5678, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_00FF}, 7'h78,
                   {32'h0012_3456, 32'h0080_0000, 32'h00FF_FFFF, 32'h0000_0000}};
        vt[8]  = '{OP_ROTMAI,  {32'h1234_5678, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_00FF}, 7'h78,
                   {32'h0012_3456, 32'hFF80_0000, 32'hFFFF_FFFF, 32'h0000_0000}};
        vt[9]  = '{OP_ROTMAHI, {8{16'h8000}},      7'h70, {8{16'hFFFF}}};
        vt[10] = '{OP_ROTHMI,  {8{16'h8000}},      7'h71, {8{16'h0001}}};
        vt[11] = '{OP_ROTMI,   {4{32'hFFFF_FFFF}}, 7'h61, {4{32'h0000_0001}}};
        vt[12] = '{OP_ROTMAI,  {4{32'h7FFF_FFFF}}, 7'h01, 128'h0};
        vt[13] = '{OP_ROTMAHI, {8{16'h8000}},      7'h01, {8{16'hFFFF}}};
        vt[14] = '{OP_ROTMI,   {4{32'h8000_0001}}, 7'h40, {4{32'h8000_0001}}};
        vt[15] = '{OP_ROTHMI,  {8{16'hF00F}},      7'h60, {8{16'hF00F}}};

        step();
        step();
        chk("reset out_valid", 128'(out_valid), 128'd0);
        chk("reset result", result, 128'h0);
        chk("reset rt_out", 128'(rt_out), 128'h0);
        reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            drive(i, 7'(i + 1));
            step();
            in_valid = 1'b0;
            chk($sformatf("vec%0d latency", i), 128'(out_valid), 128'd0);
            step();
            chk_out($sformatf("vec%0d", i), i, 7'(i + 1));
        end

        // back-to-back ops with a two-cycle stall after the second is accepted
        drive(0, 7'd21);
        step();
        chk("stall s1 empty", 128'(out_valid), 128'd0);
        drive(3, 7'd22);
        step();
        chk_out("stall op1", 0, 7'd21);
        drive(1, 7'd23);
        stall = 1'b1;
        step();
        chk_out("stall hold1", 0, 7'd21);
        step();
        chk_out("stall hold2", 0, 7'd21);
        stall = 1'b0;
        step();
        chk_out("stall op2", 3, 7'd22);
        in_valid = 1'b0;
        step();
        chk_out("stall op3", 1, 7'd23);
        step();
        chk("bubble valid", 128'(out_valid), 128'd0);
        chk("bubble result held", result, vt[1].exp);

        // flush (together with stall) kills both in-flight ops
        drive(4, 7'd31);
        step();
        drive(7, 7'd32);
        step();
        chk_out("flush pre", 4, 7'd31);
        in_valid = 1'b0;
        flush = 1'b1;
        stall = 1'b1;
        step();
        chk("flush cyc1 valid", 128'(out_valid), 128'd0);
        flush = 1'b0;
        stall = 1'b0;
        drive(8, 7'd33);
        step();
        chk("flush cyc2 valid", 128'(out_valid), 128'd0);
        in_valid = 1'b0;
        step();
        chk_out("post flush op", 8, 7'd33);

        // reset mid-stream
        drive(9, 7'd41);
        step();
        drive(10, 7'd42);
        step();
        chk_out("pre reset", 9, 7'd41);
        in_valid = 1'b0;
        reset = 1'b1;
        step();
        chk("midreset valid", 128'(out_valid), 128'd0);
        chk("midreset result", result, 128'h0);
        chk("midreset rt", 128'(rt_out), 128'h0);
        reset = 1'b0;
        drive(11, 7'd43);
        step();
        chk("post reset latency", 128'(out_valid), 128'd0);
        in_valid = 1'b0;
        step();
        chk_out("post reset op", 11, 7'd43);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
